// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, downstream instruction
// handshake, control-unit branch class and ALU flag inputs.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [11:0] opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch, beq, bne, bgt, blt, bge, ble;
    logic        flags_we;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc,
        input  imem_valid, imem_rdata, instr_ready,
        input  branch, beq, bne, bgt, blt, bge, ble,
        input  flags_we, alu_n, alu_z, alu_c, alu_v
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc,
        output imem_valid, imem_rdata, instr_ready,
        output branch, beq, bne, bgt, blt, bge, ble,
        output flags_we, alu_n, alu_z, alu_c, alu_v
    );
endinterface

// File: rtl/fetch_unit.sv
// Three-phase instruction fetch (request, wait for memory, issue downstream)
// with PC-relative branch resolution against a locally held NZCV flag register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst_n,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  flags_q, flags_d;
    logic        flag_n, flag_z, flag_v;
    logic        flag_c_unused;
    logic        taken;
    logic [31:0] target;

    assign flag_n        = flags_q[3];
    assign flag_z        = flags_q[2];
    assign flag_c_unused = flags_q[1];
    assign flag_v        = flags_q[0];

    // Several class bits high at once simply OR their conditions together.
    always_comb begin
        taken = 1'b0;
        if (bus.branch)                               taken = 1'b1;
        if (bus.beq && flag_z)                        taken = 1'b1;
        if (bus.bne && !flag_z)                       taken = 1'b1;
        if (bus.bgt && !flag_z && (flag_n == flag_v)) taken = 1'b1;
        if (bus.blt && (flag_n != flag_v))            taken = 1'b1;
        if (bus.bge && (flag_n == flag_v))            taken = 1'b1;
        if (bus.ble && (flag_z || (flag_n != flag_v))) taken = 1'b1;
    end

    assign target = pc_q + 32'd8 + {{6{instr_q[23]}}, instr_q[23:0], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_REQ:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    pc_d    = taken ? target : (pc_q + 32'd4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Flags load in any state; branch resolution above sees the old value.
    assign flags_d = bus.flags_we ? {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} : flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
        end
    end

    // Gating with rst_n keeps the request low while reset is held.
    assign bus.imem_req    = rst_n && (state_q == S_REQ);
    assign bus.instr_valid = rst_n && (state_q == S_ISSUE);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level driver predicts fetch
// addresses and held instructions; a negedge monitor compares DUT outputs.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_addr_q[$];
    item_t       exp_instr_q[$];
    logic [31:0] m_pc = 32'h0;
    logic [3:0]  m_flags = 4'h0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Architectural next-PC rule: branch condition table on the flags held
    // before this cycle, PC-relative word offset, 32-bit wraparound.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [6:0] br, input logic [3:0] f);
        bit n, z, v, take;
        int off;
        n = f[3]; z = f[2]; v = f[0];
        take = br[6] || (br[5] && z) || (br[4] && !z) || (br[3] && !z && (n == v)) ||
               (br[2] && (n != v)) || (br[1] && (n == v)) || (br[0] && (z || (n != v)));
        off = int'($signed(ins[23:0]));
        return take ? (pc + 32'd8 + 32'(off * 4)) : (pc + 32'd4);
    endfunction

    task automatic set_noise(input bit noise);
        if (noise) begin
            bus.flags_we    = ($urandom_range(0, 2) == 0);
            bus.alu_n       = 1'($urandom_range(0, 1));
            bus.alu_z       = 1'($urandom_range(0, 1));
            bus.alu_c       = 1'($urandom_range(0, 1));
            bus.alu_v       = 1'($urandom_range(0, 1));
            bus.instr_ready = 1'($urandom_range(0, 1));
            {bus.branch, bus.beq, bus.bne, bus.bgt, bus.blt, bus.bge, bus.ble} = 7'($urandom);
        end else begin
            {bus.flags_we, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 5'b0;
            bus.instr_ready = 1'b0;
            {bus.branch, bus.beq, bus.bne, bus.bgt, bus.blt, bus.bge, bus.ble} = 7'b0;
        end
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic tick();
        if (bus.flags_we) m_flags = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        @(posedge clk);
        #1;
    endtask

    // One complete fetch transaction. fl = {we,n,z,c,v} applied in the request cycle.
    task automatic run_instr(input int delay, input logic [31:0] data, input int stall,
                             input logic [6:0] br, input logic [4:0] fl, input bit noise);
        item_t       it;
        logic [31:0] nxt;
        set_noise(noise);
        if (noise) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = $urandom;
        end
        if (fl[4]) {bus.flags_we, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = fl;
        chk32("req_phase", {31'b0, bus.imem_req}, 32'd1);
        exp_addr_q.push_back(m_pc);
        tick();
        for (int i = 0; i < delay; i++) begin
            set_noise(noise);
            bus.imem_rdata = $urandom;
            chk32("wait_req_low", {31'b0, bus.imem_req}, 32'd0);
            chk32("wait_ivalid_low", {31'b0, bus.instr_valid}, 32'd0);
            tick();
        end
        set_noise(noise);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
        it.pc = m_pc;
        it.ins = data;
        exp_instr_q.push_back(it);
        chk32("wait_ivalid_low", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        for (int i = 0; i < stall; i++) begin
            set_noise(noise);
            bus.instr_ready = 1'b0;
            if (noise) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = $urandom;
            end
            chk32("issue_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk32("issue_req_low", {31'b0, bus.imem_req}, 32'd0);
            tick();
        end
        set_noise(noise);
        bus.instr_ready = 1'b1;
        {bus.branch, bus.beq, bus.bne, bus.bgt, bus.blt, bus.bge, bus.ble} = br;
        if (noise) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = $urandom;
        end
        chk32("issue_valid", {31'b0, bus.instr_valid}, 32'd1);
        nxt = model_next(m_pc, data, br, m_flags);
        tick();
        m_pc = nxt;
    endtask

    task automatic expect_addr(input string name, input logic [31:0] a);
        chk32(name, bus.imem_addr, a);
    endtask

    task automatic reset_mid_issue();
        item_t it;
        set_noise(1'b0);
        exp_addr_q.push_back(m_pc);
        tick();
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        it.pc = m_pc;
        it.ins = 32'h1234_5678;
        exp_instr_q.push_back(it);
        tick();
        bus.imem_valid = 1'b0;
        bus.instr_ready = 1'b0;
        chk32("pre_reset_valid", {31'b0, bus.instr_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk32("rst_async_ivalid", {31'b0, bus.instr_valid}, 32'd0);
        chk32("rst_async_req", {31'b0, bus.imem_req}, 32'd0);
        chk32("rst_async_pc", bus.pc, 32'h0);
        chk32("rst_async_instr", bus.instr, 32'h0);
        exp_instr_q.delete();
        exp_addr_q.delete();
        m_pc = 32'h0;
        m_flags = 4'h0;
        @(posedge clk);
        #1;
        chk32("rst_hold_req", {31'b0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk32("rst_release_req", {31'b0, bus.imem_req}, 32'd1);
        chk32("rst_release_addr", bus.imem_addr, 32'h0);
    endtask

    // Monitor: pops a predicted address per request and retires a predicted
    // instruction on each accepted issue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req) begin
                if (bus.instr_valid) chk32("req_and_valid_exclusive", 32'd1, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    chk32("unexpected_req", 32'd1, 32'd0);
                end else begin
                    logic [31:0] a;
                    a = exp_addr_q.pop_front();
                    chk32("imem_addr", bus.imem_addr, a);
                    chk32("pc_at_req", bus.pc, a);
                end
            end
            if (bus.instr_valid) begin
                if (exp_instr_q.size() == 0) begin
                    chk32("unexpected_instr_valid", 32'd1, 32'd0);
                end else begin
                    item_t e;
                    e = exp_instr_q[0];
                    chk32("instr", bus.instr, e.ins);
                    chk32("issue_pc", bus.pc, e.pc);
                    chk32("opcode", {20'b0, bus.opcode}, {20'b0, e.ins[31:20]});
                    if (bus.instr_ready) void'(exp_instr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] rbr;
        set_noise(1'b0);
        #1;
        chk32("reset_req", {31'b0, bus.imem_req}, 32'd0);
        chk32("reset_ivalid", {31'b0, bus.instr_valid}, 32'd0);
        chk32("reset_pc", bus.pc, 32'h0);
        chk32("reset_addr", bus.imem_addr, 32'h0);
        chk32("reset_instr", bus.instr, 32'h0);
        chk32("reset_opcode", {20'b0, bus.opcode}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk32("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk32("first_addr", bus.imem_addr, 32'h0);

        // Sequential stream, minimum latency.
        run_instr(0, 32'h0000_0000, 0, 7'b0, 5'b0, 1'b0); expect_addr("seq_4", 32'h4);
        run_instr(0, 32'h0000_0000, 0, 7'b0, 5'b0, 1'b0); expect_addr("seq_8", 32'h8);
        run_instr(0, 32'h0000_0000, 0, 7'b0, 5'b0, 1'b0); expect_addr("seq_c", 32'hC);
        run_instr(0, 32'h0000_0000, 0, 7'b0, 5'b0, 1'b0); expect_addr("seq_10", 32'h10);
        // Unconditional branches.
        run_instr(0, 32'hEA00_0002, 0, 7'b100_0000, 5'b0, 1'b0); expect_addr("b_fwd", 32'h20);
        run_instr(0, 32'hEAFF_FFFE, 0, 7'b100_0000, 5'b0, 1'b0); expect_addr("b_self", 32'h20);
        run_instr(0, 32'hEA00_0006, 0, 7'b100_0000, 5'b0, 1'b0); expect_addr("b_to_40", 32'h40);
        // Conditional branches on loaded flags.
        run_instr(0, 32'h0A00_0001, 0, 7'b010_0000, 5'b1_0100, 1'b0); expect_addr("beq_taken", 32'h4C);
        run_instr(0, 32'hEAFF_FFFB, 0, 7'b100_0000, 5'b0, 1'b0); expect_addr("b_back_40", 32'h40);
        run_instr(0, 32'h0A00_0001, 0, 7'b010_0000, 5'b1_0000, 1'b0); expect_addr("beq_not", 32'h44);
        run_instr(0, 32'hCA00_0001, 0, 7'b000_1000, 5'b1_1000, 1'b0); expect_addr("bgt_not", 32'h48);
        run_instr(0, 32'hDA00_0001, 0, 7'b000_0001, 5'b0, 1'b0); expect_addr("ble_taken", 32'h54);
        // Backpressure, memory stall, wrap.
        run_instr(0, 32'h1122_3344, 5, 7'b0, 5'b0, 1'b0); expect_addr("backpressure", 32'h58);
        run_instr(4, 32'h5566_7788, 0, 7'b0, 5'b0, 1'b0); expect_addr("mem_stall", 32'h5C);
        run_instr(0, 32'hEAFF_FFE6, 0, 7'b100_0000, 5'b0, 1'b0); expect_addr("b_to_top", 32'hFFFF_FFFC);
        run_instr(0, 32'h0000_0000, 0, 7'b0, 5'b0, 1'b0); expect_addr("pc_wrap", 32'h0);

        for (int k = 0; k < 150; k++) begin
            for (int b = 0; b < 7; b++) rbr[b] = ($urandom_range(0, 4) == 0);
            run_instr($urandom_range(0, 3), $urandom, $urandom_range(0, 3), rbr, 5'b0, 1'b1);
        end

        reset_mid_issue();
        for (int k = 0; k < 20; k++) begin
            for (int b = 0; b < 7; b++) rbr[b] = ($urandom_range(0, 4) == 0);
            run_instr($urandom_range(0, 3), $urandom, $urandom_range(0, 3), rbr, 5'b0, 1'b1);
        end

        chk32("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk32("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
